// File: rtl/jt49_env_sched.sv
// rtl/jt49_env_sched.sv - envelope period scheduler and restart sequencer for the JT49 envelope generator
// Decodes period/shape writes, divides cen by max(period,1) and stops one-shot shapes after 16 steps.
module jt49_env_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic        eg_cen,
  output logic        eg_rst_n,
  output logic [3:0]  ctrl,
  output logic [15:0] period,
  output logic        active
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [4:0]  step_q, step_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        eg_cen_q, eg_cen_d;
  logic        eg_rst_n_q, eg_rst_n_d;

  logic        shape_wr;
  logic [16:0] cnt_inc;
  logic [16:0] eff_period;
  logic        terminal;
  logic        one_shot;
  logic [4:0]  step_inc;

  // 17-bit compare so a period shrunk below the count fires at once instead of wrapping
  assign shape_wr   = wr && (addr == 4'hD);
  assign cnt_inc    = {1'b0, cnt_q} + 17'd1;
  assign eff_period = (period_q == 16'd0) ? 17'd1 : {1'b0, period_q};
  assign terminal   = (cnt_inc >= eff_period);
  assign one_shot   = !ctrl_q[3] || ctrl_q[0];
  assign step_inc   = (step_q == 5'd16) ? step_q : step_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    period_d   = period_q;
    ctrl_d     = ctrl_q;
    eg_cen_d   = 1'b0;
    eg_rst_n_d = 1'b1;

    if (wr) begin
      case (addr)
        4'hB:    period_d[7:0]  = din;
        4'hC:    period_d[15:8] = din;
        4'hD:    ctrl_d         = din[3:0];
        default: ;
      endcase
    end

    // A shape write overrides everything, including a terminal count on the same cycle
    if (shape_wr) begin
      state_d    = ST_RESTART;
      cnt_d      = 16'd0;
      step_d     = 5'd0;
      eg_rst_n_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESTART: begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
          step_d  = 5'd0;
        end
        ST_RUN: begin
          if (cen) begin
            if (terminal) begin
              cnt_d    = 16'd0;
              eg_cen_d = 1'b1;
              step_d   = step_inc;
              if (one_shot && (step_inc == 5'd16)) state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_inc[15:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      step_q     <= 5'd0;
      period_q   <= 16'd0;
      ctrl_q     <= 4'd0;
      eg_cen_q   <= 1'b0;
      eg_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      period_q   <= period_d;
      ctrl_q     <= ctrl_d;
      eg_cen_q   <= eg_cen_d;
      eg_rst_n_q <= eg_rst_n_d;
    end
  end

  assign eg_cen   = eg_cen_q;
  assign eg_rst_n = eg_rst_n_q;
  assign ctrl     = ctrl_q;
  assign period   = period_q;
  assign active   = (state_q == ST_RUN);

endmodule
